// File: rtl/fp16_stream_accumulator.sv
// fp16_stream_accumulator: sums in_last-delimited binary16 vectors from a valid/ready stream into one binary16 result
// Ports: clk/rst_n (async active-low reset); in_valid/in_ready/in_data/in_last element stream;
//        out_valid/out_ready/out_data/out_count result stream (count saturates at 2^CNT_W-1).
//        float16_adder: combinational binary16 adder, RNE, i_a + i_b -> o_sum.
module float16_adder (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap, w_sub, w_rnd;
  logic [15:0] w_x, w_y;
  logic [4:0]  w_ex, w_ey, w_d, w_dc, w_lz, w_sh;
  logic [13:0] w_mx, w_my, w_yal, w_m;
  logic [29:0] w_ysh;
  logic [14:0] w_s, w_r;
  logic [5:0]  w_e;
  always_comb begin
    w_a_nan = (&i_a[14:10]) & (|i_a[9:0]);
    w_b_nan = (&i_b[14:10]) & (|i_b[9:0]);
    w_a_inf = (&i_a[14:10]) & ~(|i_a[9:0]);
    w_b_inf = (&i_b[14:10]) & ~(|i_b[9:0]);
    // x is the larger magnitude, so the result takes its sign and exponent
    w_swap = i_b[14:0] > i_a[14:0];
    w_x = w_swap ? i_b : i_a;
    w_y = w_swap ? i_a : i_b;
    w_ex = (w_x[14:10] == 5'd0) ? 5'd1 : w_x[14:10];
    w_ey = (w_y[14:10] == 5'd0) ? 5'd1 : w_y[14:10];
    // mantissas carry three extra low bits: guard, round, sticky
    w_mx = {|w_x[14:10], w_x[9:0], 3'b000};
    w_my = {|w_y[14:10], w_y[9:0], 3'b000};
    w_d = w_ex - w_ey;
    w_dc = (w_d > 5'd16) ? 5'd16 : w_d;
    w_ysh = {w_my, 16'd0} >> w_dc;
    w_yal = {w_ysh[29:17], w_ysh[16] | (|w_ysh[15:0])};
    w_sub = w_x[15] ^ w_y[15];
    w_s = w_sub ? {1'b0, w_mx} - {1'b0, w_yal} : {1'b0, w_mx} + {1'b0, w_yal};
    w_lz = 5'd14;
    for (int k = 0; k < 14; k++) if (w_s[k]) w_lz = 5'(13 - k);
    // left shift is limited so the exponent never drops below 1 (subnormal results)
    w_sh = (w_lz < w_ex - 5'd1) ? w_lz : w_ex - 5'd1;
    w_m = w_s[14] ? {w_s[14:2], |w_s[1:0]} : w_s[13:0] << w_sh;
    w_e = w_s[14] ? {1'b0, w_ex} + 6'd1 : {1'b0, w_ex - w_sh};
    w_rnd = w_m[2] & ((|w_m[1:0]) | w_m[3]);
    // a mantissa carry from rounding ripples into the exponent field naturally
    w_r = {w_m[13] ? w_e[4:0] : 5'd0, w_m[12:3]} + 15'(w_rnd);
    o_sum = (w_a_nan | w_b_nan | (w_a_inf & w_b_inf & w_sub)) ? 16'h7E00 :
            w_a_inf ? i_a :
            w_b_inf ? i_b :
            (w_s == 15'd0) ? {w_x[15] & ~w_sub, 15'd0} :
            (w_e >= 6'd31) ? {w_x[15], 15'h7C00} :
            {w_x[15], w_r};
  end
endmodule

module fp16_stream_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count
);
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  state_t           r_state, w_next;
  logic [15:0]      r_acc, w_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             w_in_xfer;
  float16_adder u_add (.i_a(r_acc), .i_b(in_data), .o_sum(w_sum));
  assign w_in_xfer = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == OUT) ? (out_ready ? IDLE : OUT) :
             w_in_xfer ? (in_last ? OUT : ACC) : r_state;
  end
  always_comb begin
    in_ready = r_state != OUT;
    out_valid = r_state == OUT;
    out_data = r_acc;
    out_count = r_cnt;
  end
  // the first element bypasses the adder so -0 and single-element vectors stay bit-exact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= 16'h0000;
      r_cnt <= '0;
    end else if (w_in_xfer) begin
      r_acc <= (r_state == IDLE) ? in_data : w_sum;
      r_cnt <= (r_state == IDLE) ? CNT_W'(1) : (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fp16_stream_accumulator.sv
// tb_fp16_stream_accumulator: directed and random checks of fp16_stream_accumulator against an exact-arithmetic model
module tb_fp16_stream_accumulator;
  localparam int CNT_W = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [15:0] in_data = 16'h0000, out_data;
  logic [CNT_W-1:0] out_count;
  logic [15:0] vq[$];
  int checks = 0, errors = 0, gap_pct = 0;

  fp16_stream_accumulator #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // value of a finite half scaled by 2^24, exact as an integer
  function automatic longint fval(logic [15:0] h);
    longint m = (h[14:10] == 5'd0) ? longint'(h[9:0]) : longint'(h[9:0]) + 1024;
    int e = (h[14:10] == 5'd0) ? 1 : int'(h[14:10]);
    m = m << (e - 1);
    return h[15] ? -m : m;
  endfunction

  // round an exact nonzero scaled integer to the nearest half, ties to even
  function automatic logic [15:0] to_half(longint s);
    logic sg = s < 0;
    longint mag = sg ? -s : s;
    longint mant, rem, half;
    int p = 0, sh;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    if (mag < 1024) return {sg, 5'd0, mag[9:0]};
    sh = p - 10;
    mant = mag >> sh;
    rem = mag - (mant << sh);
    half = (sh > 0) ? (longint'(1) << (sh - 1)) : 0;
    if (sh > 0 && (rem > half || (rem == half && mant[0]))) mant++;
    if (mant == 2048) begin
      mant = 1024;
      sh++;
    end
    if (sh + 1 >= 31) return {sg, 15'h7C00};
    return {sg, 5'(sh + 1), mant[9:0]};
  endfunction

  function automatic logic [15:0] ref_add(logic [15:0] a, logic [15:0] b);
    logic an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    logic bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    logic ai = a[14:0] == 15'h7C00;
    logic bi = b[14:0] == 15'h7C00;
    longint s;
    if (an || bn) return 16'h7E00;
    if (ai && bi) return (a[15] == b[15]) ? a : 16'h7E00;
    if (ai) return a;
    if (bi) return b;
    s = fval(a) + fval(b);
    if (s == 0) return (a[15] && b[15]) ? 16'h8000 : 16'h0000;
    return to_half(s);
  endfunction

  function automatic logic [15:0] rnd_elem(logic [15:0] prev);
    int r = $urandom_range(0, 9);
    logic [15:0] h = 16'($urandom);
    if (r < 6) h[14:10] = 5'($urandom_range(10, 20));
    else if (r == 7) h[14:10] = 5'($urandom_range(0, 2));
    else if (r == 8) h = prev ^ 16'h8000;
    else if (r == 9) h[14:10] = 5'($urandom_range(26, 30));
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    if ($urandom_range(0, 99) < gap_pct) begin
      in_last = 1;
      tick();
    end
    in_valid = 1;
    in_data = d;
    in_last = l;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_in_ready", in_ready, 1);
    tick();
    in_valid = 0;
    in_last = 0;
    in_data = 16'($urandom);
  endtask

  task automatic run(input string tag, input logic [15:0] ed, input int ec, input int stall);
    foreach (vq[i]) send(vq[i], i == vq.size() - 1);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    out_ready = 0;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_hold"}, out_data, ed);
    end
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_count"}, out_count, ec);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk({tag, "_done"}, out_valid, 0);
  endtask

  initial begin
    logic [15:0] acc;
    int len;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_count", out_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    vq.delete(); vq.push_back(16'h3C00); vq.push_back(16'h4000); vq.push_back(16'h3800);
    run("sum3", 16'h4300, 3, 0);
    vq.delete(); vq.push_back(16'h8000);
    run("neg_zero", 16'h8000, 1, 0);
    vq.delete(); vq.push_back(16'hC500);
    run("single", 16'hC500, 1, 1);
    vq.delete(); vq.push_back(16'h7C00); vq.push_back(16'h3C00); vq.push_back(16'hFC00);
    run("inf_nan", 16'h7E00, 3, 0);
    vq.delete(); vq.push_back(16'h7C00); vq.push_back(16'h4000);
    run("inf_prop", 16'h7C00, 2, 0);

    send(16'h4000, 0);
    send(16'h4000, 1);
    out_ready = 0;
    in_valid = 1;
    in_data = 16'h3C00;
    in_last = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", out_data, 16'h4400);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_count", out_count, 2);
      tick();
    end
    out_ready = 1;
    tick();
    chk("bp_rel_valid", out_valid, 0);
    chk("bp_rel_in_ready", in_ready, 1);
    out_ready = 0;
    tick();
    in_valid = 0;
    in_last = 0;
    chk("bp_held_valid", out_valid, 1);
    chk("bp_held_data", out_data, 16'h3C00);
    chk("bp_held_count", out_count, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("bp_held_done", out_valid, 0);

    vq.delete();
    for (int i = 0; i < 20; i++) vq.push_back(16'h0000);
    run("saturate", 16'h0000, 15, 0);

    send(16'h3C00, 0);
    send(16'h4000, 0);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 16'h0000);
    chk("mid_rst_out_count", out_count, 0);
    tick();
    rst_n = 1;
    vq.delete(); vq.push_back(16'h3C00);
    run("after_rst", 16'h3C00, 1, 0);

    gap_pct = 25;
    for (int v = 0; v < 30; v++) begin
      len = $urandom_range(1, 20);
      vq.delete();
      vq.push_back(rnd_elem(16'h3C00));
      for (int i = 1; i < len; i++) vq.push_back(rnd_elem(vq[i - 1]));
      acc = vq[0];
      for (int i = 1; i < len; i++) acc = ref_add(acc, vq[i]);
      run($sformatf("rand%0d", v), acc, (len > 15) ? 15 : len, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
